x_skew_feeder: RTL and testbench

- Row-edge input stage of the 8x8 systolic array: accepts one activation vector per handshake (one x_w element per array row), buffers it in a small FIFO, and drives the left-edge x/x_v inputs of the PE rows.
- Applies the diagonal skew the array needs: row r receives its element r cycles after row 0.
- The top-edge mac/mac_v feed is a separate block and is out of scope.

---
 rtl/x_skew_feeder.sv | 117 +++++++++++
 tb/tb_x_skew_feeder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/x_skew_feeder.sv
// x_skew_feeder: row-edge activation FIFO followed by per-row diagonal skew
// lines that feed x/x_v into column 0 of the systolic array.
module x_skew_feeder #(
    parameter int x_w        = 8,
    parameter int rows       = 8,
    parameter int fifo_depth = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [rows*x_w-1:0] vec_i,
    input  logic                vec_v_i,
    input  logic                last_i,
    output logic                vec_rdy_o,
    input  logic                en_i,
    output logic [rows*x_w-1:0] x_o,
    output logic [rows-1:0]     x_v_o,
    output logic                last_o,
    output logic                busy_o
);
    localparam int pw = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int cw = $clog2(fifo_depth + 1);
    localparam logic [cw-1:0] depth_c = cw'(fifo_depth);
    localparam logic [pw-1:0] ptr_max = pw'(fifo_depth - 1);

    logic [rows*x_w-1:0] mem [fifo_depth];
    logic [fifo_depth-1:0] mem_last;
    logic [pw-1:0]         wr_ptr;
    logic [pw-1:0]         rd_ptr;
    logic [cw-1:0]         count;
    logic [cw-1:0]         count_next;
    logic                  push;
    logic                  pop;
    logic [rows*x_w-1:0]   head;
    logic                  head_last;
    logic [rows-1:0]       row_live;
    logic [rows-1:0]       last_line;

    assign push      = vec_v_i && vec_rdy_o;
    assign pop       = en_i && (count != '0);
    assign head      = mem[rd_ptr];
    assign head_last = mem_last[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // FIFO storage: data only, no reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr]      <= vec_i;
            mem_last[wr_ptr] <= last_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            vec_rdy_o <= 1'b0;
            busy_o    <= 1'b0;
            last_line <= '0;
        end else begin
            count <= count_next;
            if (push) wr_ptr <= (wr_ptr == ptr_max) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == ptr_max) ? '0 : rd_ptr + 1'b1;
            vec_rdy_o <= (count_next < depth_c);
            // any stage still valid after this edge: new pop or a non-final stage now
            busy_o    <= (count_next != '0) || pop || (|row_live);
            last_line <= {last_line[rows-2:0], pop && head_last};
        end
    end

    assign last_o = last_line[rows-1];

    // Skew lines: row r is r+1 stages deep, stage 0 in the LSBs
    for (genvar r = 0; r < rows; r++) begin : g_row
        logic [r:0]           vld_p;
        logic [(r+1)*x_w-1:0] dat_p;
        logic [x_w-1:0]       elem;

        assign elem = pop ? head[r*x_w +: x_w] : '0;

        if (r == 0) begin : g_first
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    vld_p <= '0;
                    dat_p <= '0;
                end else begin
                    vld_p <= pop;
                    dat_p <= elem;
                end
            end
            assign row_live[r] = 1'b0;
        end else begin : g_rest
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    vld_p <= '0;
                    dat_p <= '0;
                end else begin
                    vld_p <= {vld_p[r-1:0], pop};
                    dat_p <= {dat_p[r*x_w-1:0], elem};
                end
            end
            assign row_live[r] = |vld_p[r-1:0];
        end

        assign x_v_o[r]             = vld_p[r];
        assign x_o[r*x_w +: x_w]    = dat_p[(r+1)*x_w-1 -: x_w];
    end

endmodule

// File: tb/tb_x_skew_feeder.sv
// Bench for x_skew_feeder: directed tables and sequences plus random traffic
// checked against a queue-and-history model of the feeder.
module tb_x_skew_feeder;
    localparam int XW    = 8;
    localparam int ROWS  = 8;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [ROWS*XW-1:0]   vec_in;
    logic                 vec_v;
    logic                 last_in;
    logic                 rdy;
    logic                 en_in;
    logic [ROWS*XW-1:0]   x_o;
    logic [ROWS-1:0]      x_v;
    logic                 last_o;
    logic                 busy;

    x_skew_feeder #(.x_w(XW), .rows(ROWS), .fifo_depth(DEPTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .vec_i    (vec_in),
        .vec_v_i  (vec_v),
        .last_i   (last_in),
        .vec_rdy_o(rdy),
        .en_i     (en_in),
        .x_o      (x_o),
        .x_v_o    (x_v),
        .last_o   (last_o),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [63:0]      vec;
        logic             last;
    } rec_t;

    typedef struct {
        logic        v;
        logic        en;
        logic [63:0] vec;
        logic [7:0]  exp_xv;
        logic [63:0] exp_x;
        logic        exp_busy;
    } vec_t;

    rec_t fifo_q[$];
    rec_t hist[ROWS];
    logic m_rdy;
    logic m_busy;
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        fifo_q.delete();
        for (int i = 0; i < ROWS; i++) hist[i] = '{1'b0, 64'h0, 1'b0};
        m_rdy  = 1'b0;
        m_busy = 1'b0;
    endtask

    // One clock edge: pop the head (if enabled), then accept the input if ready.
    task automatic model_edge(input logic v, input logic [63:0] vec, input logic last,
                              input logic en);
        rec_t popped;
        logic pushed;
        popped = '{1'b0, 64'h0, 1'b0};
        if (!rst_n) return;
        pushed = v && m_rdy;
        if (en && fifo_q.size() > 0) begin
            popped   = fifo_q.pop_front();
            popped.v = 1'b1;
        end
        if (pushed) fifo_q.push_back('{1'b1, vec, last});
        for (int i = ROWS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = popped;
        m_rdy  = (fifo_q.size() < DEPTH);
        m_busy = (fifo_q.size() != 0);
        for (int i = 0; i < ROWS; i++) if (hist[i].v) m_busy = 1'b1;
    endtask

    task automatic check_all();
        logic [63:0] ex;
        logic [7:0]  exv;
        logic        el;
        ex  = '0;
        exv = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (hist[r].v) begin
                exv[r]         = 1'b1;
                ex[r*XW +: XW] = hist[r].vec[r*XW +: XW];
            end
        end
        el = hist[ROWS-1].v && hist[ROWS-1].last;
        chk("x_o", x_o, ex);
        chk("x_v_o", 64'(x_v), 64'(exv));
        chk("last_o", 64'(last_o), 64'(el));
        chk("vec_rdy_o", 64'(rdy), 64'(m_rdy));
        chk("busy_o", 64'(busy), 64'(m_busy));
    endtask

    task automatic step(input logic v, input logic [63:0] vec, input logic last,
                        input logic en);
        vec_v   = v;
        vec_in  = vec;
        last_in = last;
        en_in   = en;
        @(posedge clk);
        model_edge(v, vec, last, en);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'h0, 1'b0, 1'b1);
    endtask

    vec_t tbl[10];
    int   accepted;
    logic [3:0] row0_pat;
    logic [3:0] row7_pat;
    int   last_cnt;
    logic [7:0] last_dat;

    initial begin
        rst_n = 1'b0; vec_v = 1'b0; vec_in = '0; last_in = 1'b0; en_in = 1'b0;
        model_reset();

        tbl[0] = '{1'b1, 1'b1, 64'h0807060504030201, 8'h00, 64'h0, 1'b1};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b0, 1'b1, 64'h0, 8'(1 << (i - 1)), 64'(i) << ((i - 1) * 8), 1'b1};
        tbl[9] = '{1'b0, 1'b1, 64'h0, 8'h00, 64'h0, 1'b0};

        // reset state
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rdy_before_first_edge", 64'(rdy), 64'h0);
        idle(1);
        chk("rdy_after_first_edge", 64'(rdy), 64'h1);

        // single vector, table driven
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].vec, 1'b0, tbl[i].en);
            chk("single_xv", 64'(x_v), 64'(tbl[i].exp_xv));
            chk("single_x", x_o, tbl[i].exp_x);
            chk("single_busy", 64'(busy), 64'(tbl[i].exp_busy));
        end

        // back-to-back
        for (int i = 0; i < 6; i++) begin
            step(1'b1, {8{8'(i)}}, 1'b0, 1'b1);
            chk("b2b_rdy", 64'(rdy), 64'h1);
        end
        idle(10);

        // fill and backpressure
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            if (rdy) accepted++;
            step(1'b1, {8{8'(8'h10 + i)}}, 1'b0, 1'b0);
        end
        chk("fill_accepted", 64'(accepted), 64'd4);
        chk("fill_rdy_low", 64'(rdy), 64'h0);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        chk("rdy_reassert", 64'(rdy), 64'h1);
        idle(12);

        // bubble insertion
        row0_pat = '0;
        row7_pat = '0;
        for (int i = 0; i < 14; i++) begin
            case (i)
                0: step(1'b1, {8{8'h21}}, 1'b0, 1'b1);
                1: step(1'b1, {8{8'h22}}, 1'b0, 1'b1);
                2: step(1'b1, {8{8'h23}}, 1'b0, 1'b0);
                default: step(1'b0, 64'h0, 1'b0, 1'b1);
            endcase
            if (i >= 1 && i <= 4) row0_pat[4 - i] = x_v[0];
            if (i >= 8 && i <= 11) row7_pat[11 - i] = x_v[7];
        end
        chk("bubble_row0", 64'(row0_pat), 64'hB);
        chk("bubble_row7", 64'(row7_pat), 64'hB);

        // last alignment
        last_cnt = 0;
        last_dat = '0;
        for (int i = 0; i < 15; i++) begin
            if (i < 3) step(1'b1, {8{8'(8'h31 + i)}}, (i == 2), 1'b1);
            else       step(1'b0, 64'h0, 1'b0, 1'b1);
            if (last_o) begin
                last_cnt++;
                last_dat = x_o[63:56];
            end
        end
        chk("last_count", 64'(last_cnt), 64'd1);
        chk("last_row7_data", 64'(last_dat), 64'h33);

        // reset mid-stream: 2 in FIFO, 1 in skew lines
        for (int i = 0; i < 3; i++) step(1'b1, {8{8'(8'h41 + i)}}, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        en_in = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy_before_edge", 64'(rdy), 64'h0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 64'h0, 1'b0, 1'b1);
            chk("rst_no_valid", 64'(x_v), 64'h0);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        idle(12);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
